bits_op_pipe: RTL

Pipelined successor to the single-cycle bitwise execution unit in the RISC-V ALU cluster. It widens the op set from AND/OR/XOR to the Zbb logic-with-negate and bit-count ops (ANDN, ORN, XNOR, CLZ, CTZ, CPOP, plus the W variants on RV64). It sits between issue and writeback behind a fixed 2-stage valid/ready pipeline and supports backpressure, flush and transaction tags.

---
 rtl/bits_op_pkg.sv | 40 ++++
 rtl/bits_op_pipe_cnt_half.sv | 22 ++
 rtl/bits_op_pipe.sv | 100 ++++++++++
 3 files changed

// File: rtl/bits_op_pkg.sv
// bits_op_pkg: opcodes, legality helpers and the S1->S2 stage record for bits_op_pipe.
package bits_op_pkg;
    localparam int XLEN_MAX = 64;
    localparam int TAG_MAX = 16;
    localparam int CNT_W = 6;

    typedef enum logic [3:0] {
        OP_AND  = 4'd0,
        OP_OR   = 4'd1,
        OP_XOR  = 4'd2,
        OP_ANDN = 4'd3,
        OP_ORN  = 4'd4,
        OP_XNOR = 4'd5,
        OP_CLZ  = 4'd6,
        OP_CTZ  = 4'd7,
        OP_CPOP = 4'd8
    } op_e;

    function automatic logic is_cnt_op(input logic [3:0] op);
        return op == OP_CLZ || op == OP_CTZ || op == OP_CPOP;
    endfunction

    function automatic logic is_legal(input logic [3:0] op, input logic w, input logic rv64);
        return op <= OP_CPOP && !(w && (!is_cnt_op(op) || !rv64));
    endfunction

    typedef struct packed {
        logic [3:0]          op;
        logic                w;
        logic                ill;
        logic [XLEN_MAX-1:0] res;
        logic [CNT_W-1:0]    hi_clz;
        logic [CNT_W-1:0]    lo_clz;
        logic [CNT_W-1:0]    hi_pop;
        logic [CNT_W-1:0]    lo_pop;
        logic                hi_zero;
        logic                lo_zero;
        logic [TAG_MAX-1:0]  tag;
    } stage_t;
endpackage

// File: rtl/bits_op_pipe_cnt_half.sv
// bits_cnt_half: leading-zero count, popcount and all-zero flag of an N-bit slice.
module bits_cnt_half #(
    parameter int N = 16
) (
    input  logic [N-1:0]         x,
    output logic [$clog2(N):0]   clz,
    output logic [$clog2(N):0]   pop,
    output logic                 zero
);
    localparam int CW = $clog2(N) + 1;

    always_comb begin
        clz = CW'(N);
        pop = '0;
        for (int i = 0; i < N; i++) begin
            if (x[i]) clz = CW'(N - 1 - i);
            pop = pop + CW'(x[i]);
        end
    end

    assign zero = ~|x;
endmodule

// File: rtl/bits_op_pipe.sv
// bits_op_pipe: 2-stage valid/ready Zbb logic and bit-count unit.
module bits_op_pipe
    import bits_op_pkg::*;
#(
    parameter bit RV64 = 0,
    parameter int TAG_W = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          flush,
    input  logic                          in_vld,
    output logic                          in_rdy,
    input  logic [3:0]                    in_op,
    input  logic                          in_w,
    input  logic [(RV64 ? 64 : 32)-1:0]   in_s1,
    input  logic [(RV64 ? 64 : 32)-1:0]   in_s2,
    input  logic [TAG_W-1:0]              in_tag,
    output logic                          out_vld,
    input  logic                          out_rdy,
    output logic [(RV64 ? 64 : 32)-1:0]   out_rslt,
    output logic [TAG_W-1:0]              out_tag,
    output logic                          out_ill
);
    localparam int XLEN = RV64 ? 64 : 32;
    localparam int H = XLEN / 2;
    localparam int CW = $clog2(H) + 1;

    logic s1_vld, s2_vld, s2_adv, ill, unused_s2;
    stage_t s1_q, s2_q, s1_d;
    logic [XLEN-1:0] x_rev, cx, lres;
    logic [31:0] v;
    logic [H-1:0] hi_x, lo_x;
    logic [CW-1:0] hi_clz, lo_clz, hi_pop, lo_pop;
    logic hi_zero, lo_zero;
    logic [6:0] half, lo_c, cnt;

    // CTZ is CLZ of the reversed operand; W ops pack 16-bit halves MSB-aligned in each slice
    always_comb begin
        for (int i = 0; i < XLEN; i++) x_rev[i] = in_s1[XLEN-1-i];
        for (int i = 0; i < 32; i++) v[i] = in_op == OP_CTZ ? in_s1[31-i] : in_s1[i];
        cx = in_op == OP_CTZ ? x_rev : in_s1;
        hi_x = in_w ? H'({v[31:16], 16'h0}) : cx[XLEN-1:H];
        lo_x = in_w ? H'({v[15:0], 16'h0}) : cx[H-1:0];
    end

    bits_cnt_half #(.N(H)) u_hi (.x(hi_x), .clz(hi_clz), .pop(hi_pop), .zero(hi_zero));
    bits_cnt_half #(.N(H)) u_lo (.x(lo_x), .clz(lo_clz), .pop(lo_pop), .zero(lo_zero));

    always_comb begin
        lres = in_op == OP_AND  ? in_s1 & in_s2 :
               in_op == OP_OR   ? in_s1 | in_s2 :
               in_op == OP_XOR  ? in_s1 ^ in_s2 :
               in_op == OP_ANDN ? in_s1 & ~in_s2 :
               in_op == OP_ORN  ? in_s1 | ~in_s2 :
               in_op == OP_XNOR ? ~(in_s1 ^ in_s2) : '0;
        ill = !is_legal(in_op, in_w, RV64);
        s1_d = '{op: in_op, w: in_w, ill: ill,
                 res: (ill || is_cnt_op(in_op)) ? '0 : XLEN_MAX'(lres),
                 hi_clz: CNT_W'(hi_clz), lo_clz: CNT_W'(lo_clz),
                 hi_pop: CNT_W'(hi_pop), lo_pop: CNT_W'(lo_pop),
                 hi_zero: hi_zero, lo_zero: lo_zero, tag: TAG_MAX'(in_tag)};
    end

    // an all-zero W low half reports 32 from its slice but only contributes 16
    always_comb begin
        half = s2_q.w ? 7'd16 : 7'(H);
        lo_c = (s2_q.w && s2_q.lo_zero) ? 7'd16 : 7'(s2_q.lo_clz);
        cnt = s2_q.op == OP_CPOP ? 7'(s2_q.hi_pop) + 7'(s2_q.lo_pop) :
              s2_q.hi_zero ? half + lo_c : 7'(s2_q.hi_clz);
        out_rslt = s2_q.ill ? '0 : is_cnt_op(s2_q.op) ? XLEN'(cnt) : s2_q.res[XLEN-1:0];
    end

    assign s2_adv = !s2_vld || out_rdy;
    assign in_rdy = !s1_vld || s2_adv;
    assign out_vld = s2_vld;
    assign out_tag = s2_q.tag[TAG_W-1:0];
    assign out_ill = s2_q.ill;
    assign unused_s2 = ^s2_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_vld <= 1'b0;
            s2_vld <= 1'b0;
            s1_q <= '0;
            s2_q <= '0;
        end else if (flush) begin
            s1_vld <= 1'b0;
            s2_vld <= 1'b0;
        end else begin
            if (s2_adv) begin
                s2_vld <= s1_vld;
                if (s1_vld) s2_q <= s1_q;
            end
            if (in_rdy) begin
                s1_vld <= in_vld;
                if (in_vld) s1_q <= s1_d;
            end
        end
    end
endmodule
